// File: rtl/ariane_pkg.sv
// rtl/ariane_pkg.sv - shared ids and divider opcode encoding
package ariane_pkg;

  localparam int unsigned TRANS_ID_BITS = 3;

  typedef enum logic [1:0] {
    UDIV = 2'd0,
    DIV  = 2'd1,
    UREM = 2'd2,
    REM  = 2'd3
  } div_opcode_e;

  // Bit 0 of the opcode selects the signed flavour of both div and rem.
  function automatic logic is_signed_op(input logic [1:0] op);
    return op[0];
  endfunction

endpackage

// File: rtl/div_result_cache.sv
// rtl/div_result_cache.sv - one-entry key/result cache in front of the serial divider
module div_result_cache #(
  parameter int unsigned KEY_W  = 131,
  parameter int unsigned RES_W  = 64,
  parameter bit          ENABLE = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [KEY_W-1:0] lookup_key,
  output logic             hit,
  output logic [RES_W-1:0] hit_result,
  input  logic             wr_en,
  input  logic [KEY_W-1:0] wr_key,
  input  logic [RES_W-1:0] wr_result
);

  if (ENABLE) begin : g_cache
    logic             valid_q;
    logic [KEY_W-1:0] key_q;
    logic [RES_W-1:0] result_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        valid_q  <= 1'b0;
        key_q    <= '0;
        result_q <= '0;
      end else if (wr_en) begin
        valid_q  <= 1'b1;
        key_q    <= wr_key;
        result_q <= wr_result;
      end
    end

    assign hit        = valid_q && (key_q == lookup_key);
    assign hit_result = result_q;
  end else begin : g_nocache
    assign hit        = 1'b0;
    assign hit_result = '0;
  end

endmodule

// File: rtl/div_ctrl.sv
// rtl/div_ctrl.sv - operand conditioning, handshake and writeback buffer around the serial divider
module div_ctrl
  import ariane_pkg::*;
#(
  parameter int unsigned WIDTH        = 64,
  parameter bit          ENABLE_CACHE = 1'b1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     req_valid_i,
  output logic                     req_ready_o,
  input  logic [1:0]               req_opcode_i,
  input  logic                     req_word_i,
  input  logic [WIDTH-1:0]         req_op_a_i,
  input  logic [WIDTH-1:0]         req_op_b_i,
  input  logic [TRANS_ID_BITS-1:0] req_id_i,
  output logic [TRANS_ID_BITS-1:0] div_id_o,
  output logic [WIDTH-1:0]         div_op_a_o,
  output logic [WIDTH-1:0]         div_op_b_o,
  output logic [1:0]               div_opcode_o,
  output logic                     div_in_vld_o,
  input  logic                     div_in_rdy_i,
  output logic                     div_flush_o,
  input  logic                     div_out_vld_i,
  output logic                     div_out_rdy_o,
  input  logic [TRANS_ID_BITS-1:0] div_id_i,
  input  logic [WIDTH-1:0]         div_res_i,
  output logic                     wb_valid_o,
  input  logic                     wb_ready_i,
  output logic [TRANS_ID_BITS-1:0] wb_id_o,
  output logic [WIDTH-1:0]         wb_result_o
);

  localparam int unsigned KEY_W = 2 * WIDTH + 3;

  typedef enum logic [1:0] {IDLE, LAUNCH, BUSY, HOLD} state_e;

  state_e                   state_q;
  logic                     div_rdy_q;
  logic [WIDTH-1:0]         op_a_q;
  logic [WIDTH-1:0]         op_b_q;
  logic [WIDTH-1:0]         res_q;
  div_opcode_e              opcode_q;
  logic                     word_q;
  logic [TRANS_ID_BITS-1:0] id_q;

  logic [WIDTH-1:0] cond_a;
  logic [WIDTH-1:0] cond_b;
  logic [WIDTH-1:0] res_adj;
  logic [WIDTH-1:0] cache_result;
  logic             cache_hit;
  logic             accept;
  logic             res_take;

  function automatic logic [WIDTH-1:0] condition(input logic [WIDTH-1:0] v,
                                                 input logic word, input logic sext);
    if (!word) return v;
    return {{(WIDTH-32){sext & v[31]}}, v[31:0]};
  endfunction

  assign cond_a = condition(req_op_a_i, req_word_i, is_signed_op(req_opcode_i));
  assign cond_b = condition(req_op_b_i, req_word_i, is_signed_op(req_opcode_i));

  // Word results are always sign-extended from bit 31, unsigned variants included.
  assign res_adj = word_q ? {{(WIDTH-32){div_res_i[31]}}, div_res_i[31:0]} : div_res_i;

  assign req_ready_o   = (state_q == IDLE) && div_rdy_q && !flush_i;
  assign accept        = req_valid_i && req_ready_o;
  assign res_take      = (state_q == BUSY) && div_out_vld_i && !flush_i;

  assign div_in_vld_o  = (state_q == LAUNCH) && !flush_i;
  assign div_out_rdy_o = (state_q == BUSY) && !flush_i;
  assign wb_valid_o    = (state_q == HOLD) && !flush_i;
  assign div_flush_o   = flush_i;

  assign div_id_o      = id_q;
  assign div_op_a_o    = op_a_q;
  assign div_op_b_o    = op_b_q;
  assign div_opcode_o  = opcode_q;
  assign wb_id_o       = id_q;
  assign wb_result_o   = res_q;

  div_result_cache #(
    .KEY_W  (KEY_W),
    .RES_W  (WIDTH),
    .ENABLE (ENABLE_CACHE)
  ) i_cache (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .lookup_key ({cond_a, cond_b, req_opcode_i, req_word_i}),
    .hit        (cache_hit),
    .hit_result (cache_result),
    .wr_en      (res_take),
    .wr_key     ({op_a_q, op_b_q, opcode_q, word_q}),
    .wr_result  (res_adj)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      div_rdy_q <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      res_q     <= '0;
      opcode_q  <= UDIV;
      word_q    <= 1'b0;
      id_q      <= '0;
    end else begin
      div_rdy_q <= div_in_rdy_i;
      if (flush_i) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (accept) begin
              op_a_q   <= cond_a;
              op_b_q   <= cond_b;
              opcode_q <= div_opcode_e'(req_opcode_i);
              word_q   <= req_word_i;
              id_q     <= req_id_i;
              if (cache_hit) begin
                res_q   <= cache_result;
                state_q <= HOLD;
              end else begin
                state_q <= LAUNCH;
              end
            end
          end
          // The divider is known idle here, so it loads without a ready check.
          LAUNCH: state_q <= BUSY;
          BUSY: begin
            if (div_out_vld_i) begin
              res_q   <= res_adj;
              state_q <= HOLD;
            end
          end
          HOLD: begin
            if (wb_ready_i) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  busy_id_match : assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == BUSY && div_out_vld_i) |-> (div_id_i == id_q));

endmodule
